// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared write-back source encoding and sizing helper
package regfile_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_PIPE = 2'd1,
        WB_SRC_RL   = 2'd2,
        WB_SRC_LL   = 2'd3
    } wb_src_e;

    // Never returns 0 so single-entry structures still get a 1-bit index.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small circular FIFO, ready from registered count only
module bsg_fifo_1r1w_small
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               empty_o
);
    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  r_mem [els_p];
    logic [ptr_w_lp-1:0] r_rd_ptr;
    logic [ptr_w_lp-1:0] r_wr_ptr;
    logic [cnt_w_lp-1:0] r_count;
    logic                w_enq;
    logic                w_deq;

    assign ready_o = (r_count != cnt_w_lp'(els_p));
    assign empty_o = (r_count == '0);
    assign v_o     = ~empty_o;
    assign data_o  = r_mem[r_rd_ptr];
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_deq) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges pipeline, remote-load and long-latency write-backs
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int width_p           = 32,
    parameter int els_p             = 32,
    parameter int x0_tied_to_zero_p = 1,
    parameter int rl_els_p          = 2,
    parameter int starve_limit_p    = 4,
    localparam int addr_width_lp    = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     pipe_w_v_i,
    input  logic [addr_width_lp-1:0] pipe_w_addr_i,
    input  logic [width_p-1:0]       pipe_w_data_i,
    input  logic                     ll_v_i,
    input  logic [addr_width_lp-1:0] ll_addr_i,
    input  logic [width_p-1:0]       ll_data_i,
    output logic                     ll_yumi_o,
    input  logic                     rl_v_i,
    input  logic [addr_width_lp-1:0] rl_addr_i,
    input  logic [width_p-1:0]       rl_data_i,
    output logic                     rl_ready_o,
    output logic                     rl_empty_o,
    output logic                     stall_pipe_o,
    output logic                     w_v_o,
    output logic [addr_width_lp-1:0] w_addr_o,
    output logic [width_p-1:0]       w_data_o,
    output wb_src_e                  w_src_o
);
    localparam int cnt_w_lp = $clog2(starve_limit_p + 1);

    logic                     w_rl_head_v;
    logic [addr_width_lp-1:0] w_rl_head_addr;
    logic [width_p-1:0]       w_rl_head_data;
    logic                     w_sel_v;
    logic [addr_width_lp-1:0] w_sel_addr;
    logic [width_p-1:0]       w_sel_data;
    wb_src_e                  w_sel_src;
    logic                     w_rl_deq;
    logic                     w_ll_win;
    logic                     w_x0;
    logic                     w_pending;
    logic [cnt_w_lp-1:0]      w_cnt_next;

    logic [cnt_w_lp-1:0]      r_cnt;
    logic                     r_stall;
    logic                     r_v;
    logic [addr_width_lp-1:0] r_addr;
    logic [width_p-1:0]       r_data;
    wb_src_e                  r_src;

    bsg_fifo_1r1w_small #(
        .width_p (width_p + addr_width_lp),
        .els_p   (rl_els_p)
    ) rl_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (rl_v_i),
        .data_i  ({rl_addr_i, rl_data_i}),
        .ready_o (rl_ready_o),
        .v_o     (w_rl_head_v),
        .data_o  ({w_rl_head_addr, w_rl_head_data}),
        .yumi_i  (w_rl_deq & ~reset_i),
        .empty_o (rl_empty_o)
    );

    // Fixed priority: pipe, then buffered remote load, then long-latency unit.
    always_comb begin
        w_sel_v    = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_src  = WB_SRC_NONE;
        w_rl_deq   = 1'b0;
        w_ll_win   = 1'b0;
        if (pipe_w_v_i) begin
            w_sel_v    = 1'b1;
            w_sel_addr = pipe_w_addr_i;
            w_sel_data = pipe_w_data_i;
            w_sel_src  = WB_SRC_PIPE;
        end else if (w_rl_head_v) begin
            w_sel_v    = 1'b1;
            w_sel_addr = w_rl_head_addr;
            w_sel_data = w_rl_head_data;
            w_sel_src  = WB_SRC_RL;
            w_rl_deq   = 1'b1;
        end else if (ll_v_i) begin
            w_sel_v    = 1'b1;
            w_sel_addr = ll_addr_i;
            w_sel_data = ll_data_i;
            w_sel_src  = WB_SRC_LL;
            w_ll_win   = 1'b1;
        end
    end

    assign ll_yumi_o = w_ll_win & ~reset_i;
    assign w_x0      = (x0_tied_to_zero_p != 0) && (w_sel_addr == '0);
    assign w_pending = w_rl_head_v | ll_v_i;

    always_comb begin
        w_cnt_next = '0;
        if (pipe_w_v_i && w_pending) begin
            w_cnt_next = (r_cnt == cnt_w_lp'(starve_limit_p)) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt   <= '0;
            r_stall <= 1'b0;
            r_v     <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_src   <= WB_SRC_NONE;
        end else begin
            r_cnt   <= w_cnt_next;
            r_stall <= (w_cnt_next == cnt_w_lp'(starve_limit_p));
            r_v     <= w_sel_v & ~w_x0;
            r_src   <= w_x0 ? WB_SRC_NONE : w_sel_src;
            if (w_sel_v) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
        end
    end

    assign stall_pipe_o = r_stall;
    assign w_v_o        = r_v;
    assign w_addr_o     = r_addr;
    assign w_data_o     = r_data;
    assign w_src_o      = r_src;

endmodule
